// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word 1011 then payload MSB first, one bit per clock.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_nxt;
    logic [SYNC_W-1:0]   sync_sh;

`ifdef SEQ_FRAME_TX_PARITY_EN
    logic                par;
    logic                par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            IDLE: begin
                if (data_valid) begin
                    state_nxt = SYNC;
                    cnt_nxt   = '0;
                    shreg_nxt = data_in;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            SYNC: begin
                if (cnt == SYNC_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                shreg_nxt = shreg << 1;
                if (cnt == DATA_LAST) begin
                    cnt_nxt = '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Sync bit selected by shifting the pattern so the counter never indexes directly
    assign sync_sh = SYNC_PATTERN << cnt;

    always_comb begin
        data_ready  = 1'b0;
        out_bit     = 1'b0;
        out_valid   = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
                data_ready = 1'b1;
            end
            SYNC: begin
                out_valid   = 1'b1;
                out_bit     = sync_sh[SYNC_W-1];
                frame_start = (cnt == '0);
            end
            DATA: begin
                out_valid = 1'b1;
                out_bit   = shreg[DATA_W-1];
`ifndef SEQ_FRAME_TX_PARITY_EN
                frame_done = (cnt == DATA_LAST);
`endif
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PARITY: begin
                out_valid  = 1'b1;
                out_bit    = par;
                frame_done = 1'b1;
            end
`endif
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

endmodule
